// File: rtl/pc_stack.sv
// Program counter with a circular return-address stack, stepped on one instruction phase.
// Optional sticky overflow/underflow flags are built when PC_STACK_FLAGS_EN is defined.
module pc_stack #(
    parameter int ADDR_W     = 12,
    parameter int DEPTH      = 3,
    parameter int STEP_CYCLE = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 i_cycle,
    input  logic                       i_advance,
    input  logic                       i_jump,
    input  logic                       i_call,
    input  logic                       i_ret,
    input  logic [ADDR_W-1:0]          i_target,
    input  logic                       i_flag_clr,
    output logic [ADDR_W-1:0]          o_pc_addr,
    output logic [$clog2(DEPTH+1)-1:0] o_stack_depth,
    output logic                       o_stack_overflow,
    output logic                       o_stack_underflow
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] r_pc;
    logic [PW-1:0]     r_wp;
    logic [CW-1:0]     r_count;
    logic [ADDR_W-1:0] r_mem [DEPTH];

    logic              w_step;
    logic              w_do_call;
    logic              w_do_jump;
    logic              w_do_ret;
    logic              w_do_adv;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [PW-1:0]     w_wp_inc;
    logic [PW-1:0]     w_wp_dec;
    logic [ADDR_W-1:0] w_pc_next;
    logic [PW-1:0]     w_wp_next;
    logic [CW-1:0]     w_count_next;

    assign w_step    = (i_cycle == 3'(STEP_CYCLE));
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pc_inc  = r_pc + 1'b1;
    assign w_wp_inc  = (r_wp == PW'(DEPTH-1)) ? '0 : r_wp + 1'b1;
    assign w_wp_dec  = (r_wp == '0) ? PW'(DEPTH-1) : r_wp - 1'b1;

    // Fixed priority: call > jump > ret > advance.
    assign w_do_call = w_step & i_call;
    assign w_do_jump = w_step & ~i_call & i_jump;
    assign w_do_ret  = w_step & ~i_call & ~i_jump & i_ret;
    assign w_do_adv  = w_step & ~i_call & ~i_jump & ~i_ret & i_advance;

    always_comb begin
        w_pc_next    = r_pc;
        w_wp_next    = r_wp;
        w_count_next = r_count;
        if (w_do_call) begin
            w_pc_next = i_target;
            w_wp_next = w_wp_inc;
            if (!w_full) w_count_next = r_count + 1'b1;
        end else if (w_do_jump) begin
            w_pc_next = i_target;
        end else if (w_do_ret) begin
            if (w_empty) begin
                w_pc_next = w_pc_inc;
            end else begin
                w_pc_next    = r_mem[w_wp_dec];
                w_wp_next    = w_wp_dec;
                w_count_next = r_count - 1'b1;
            end
        end else if (w_do_adv) begin
            w_pc_next = w_pc_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= '0;
            r_wp    <= '0;
            r_count <= '0;
        end else begin
            r_pc    <= w_pc_next;
            r_wp    <= w_wp_next;
            r_count <= w_count_next;
        end
    end

    // A push into a full stack simply overwrites the oldest slot, which sits at wp.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mem[gi] <= '0;
                end else if (w_do_call && (r_wp == PW'(gi))) begin
                    r_mem[gi] <= w_pc_inc;
                end
            end
        end
    endgenerate

`ifdef PC_STACK_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // A set event on the same edge as flag_clr leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_do_call && w_full)      r_overflow <= 1'b1;
            else if (i_flag_clr)          r_overflow <= 1'b0;
            if (w_do_ret && w_empty)      r_underflow <= 1'b1;
            else if (i_flag_clr)          r_underflow <= 1'b0;
        end
    end

    assign o_stack_overflow  = r_overflow;
    assign o_stack_underflow = r_underflow;
`else
    logic w_unused_clr;
    assign w_unused_clr      = i_flag_clr;
    assign o_stack_overflow  = 1'b0;
    assign o_stack_underflow = 1'b0;
`endif

    assign o_pc_addr     = r_pc;
    assign o_stack_depth = r_count;

endmodule

// File: tb/tb_pc_stack.sv
// Directed-vector bench for pc_stack (ADDR_W=12, DEPTH=3, STEP_CYCLE=7); flag
// expectations follow PC_STACK_FLAGS_EN.
module tb_pc_stack;
`ifdef PC_STACK_FLAGS_EN
    localparam logic FL = 1'b1;
`else
    localparam logic FL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  cycle = 3'd0;
    logic        advance = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0, flag_clr = 1'b0;
    logic [11:0] target = 12'h000;
    logic [11:0] pc_addr;
    logic [1:0]  stack_depth;
    logic        ovf, unf;

    int n_vec = 0;
    int n_bad = 0;

    pc_stack #(.ADDR_W(12), .DEPTH(3), .STEP_CYCLE(7)) dut (
        .clk(clk), .rst(rst), .i_cycle(cycle),
        .i_advance(advance), .i_jump(jump), .i_call(call), .i_ret(ret),
        .i_target(target), .i_flag_clr(flag_clr),
        .o_pc_addr(pc_addr), .o_stack_depth(stack_depth),
        .o_stack_overflow(ovf), .o_stack_underflow(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Apply one command set on a given phase, then sample #1 after the edge.
    task automatic cmd(input logic [2:0] cyc, input logic a, input logic j, input logic c,
                       input logic r, input logic [11:0] t, input logic clr);
        cycle = cyc; advance = a; jump = j; call = c; ret = r; target = t; flag_clr = clr;
        @(posedge clk);
        #1;
        advance = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; flag_clr = 1'b0; cycle = 3'd0;
    endtask

    task automatic chk_state(input string tag, input logic [11:0] pc, input logic [1:0] d,
                             input logic o, input logic u);
        chk({tag, ".pc"}, 32'(pc_addr), 32'(pc));
        chk({tag, ".depth"}, 32'(stack_depth), 32'(d));
        chk({tag, ".ovf"}, 32'(ovf), 32'(o));
        chk({tag, ".unf"}, 32'(unf), 32'(u));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 12'h000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 1; i <= 5; i++) begin
            cmd(3'd7, 1, 0, 0, 0, 12'h000, 0);
            chk($sformatf("adv%0d.pc", i), 32'(pc_addr), 32'(i));
        end
        for (int c = 0; c < 7; c++) cmd(3'(c), 1, 1, 1, 1, 12'h777, 0);
        chk_state("offphase", 12'h005, 2'd0, 1'b0, 1'b0);

        cmd(3'd7, 0, 1, 0, 0, 12'hFFF, 0);
        chk("jmp_fff.pc", 32'(pc_addr), 32'h0FFF);
        cmd(3'd7, 1, 0, 0, 0, 12'h000, 0);
        chk_state("wrap", 12'h000, 2'd0, 1'b0, 1'b0);
        cmd(3'd7, 0, 0, 0, 0, 12'h123, 0);
        chk("idle.pc", 32'(pc_addr), 32'h0000);

        cmd(3'd7, 0, 1, 0, 0, 12'h010, 0);
        cmd(3'd7, 0, 0, 1, 0, 12'h200, 0);
        chk_state("call1", 12'h200, 2'd1, 1'b0, 1'b0);
        cmd(3'd7, 0, 0, 1, 0, 12'h300, 0);
        chk_state("call2", 12'h300, 2'd2, 1'b0, 1'b0);
        cmd(3'd7, 0, 0, 0, 1, 12'h000, 0);
        chk_state("ret1", 12'h201, 2'd1, 1'b0, 1'b0);
        cmd(3'd7, 0, 0, 0, 1, 12'h000, 0);
        chk_state("ret2", 12'h011, 2'd0, 1'b0, 1'b0);

        cmd(3'd7, 0, 1, 0, 0, 12'h100, 0);
        cmd(3'd7, 0, 0, 1, 0, 12'h101, 0);
        cmd(3'd7, 0, 0, 1, 0, 12'h102, 0);
        cmd(3'd7, 0, 0, 1, 0, 12'h103, 0);
        chk_state("full", 12'h103, 2'd3, 1'b0, 1'b0);
        cmd(3'd7, 0, 0, 1, 0, 12'h104, 0);
        chk_state("ovf_call", 12'h104, 2'd3, FL, 1'b0);
        cmd(3'd7, 0, 0, 0, 1, 12'h000, 0);
        chk_state("oret1", 12'h104, 2'd2, FL, 1'b0);
        cmd(3'd7, 0, 0, 0, 1, 12'h000, 0);
        chk_state("oret2", 12'h103, 2'd1, FL, 1'b0);
        cmd(3'd7, 0, 0, 0, 1, 12'h000, 0);
        chk_state("oret3", 12'h102, 2'd0, FL, 1'b0);
        cmd(3'd7, 0, 0, 0, 1, 12'h000, 0);
        chk_state("uret", 12'h103, 2'd0, FL, FL);
        cmd(3'd3, 0, 0, 0, 0, 12'h000, 1);
        chk_state("clr", 12'h103, 2'd0, 1'b0, 1'b0);
        cmd(3'd7, 0, 0, 0, 1, 12'h000, 1);
        chk_state("set_wins", 12'h104, 2'd0, 1'b0, FL);
        cmd(3'd2, 0, 0, 0, 0, 12'h000, 1);
        chk("clr2.unf", 32'(unf), 32'h0);

        cmd(3'd7, 0, 1, 0, 0, 12'h050, 0);
        cmd(3'd7, 1, 1, 1, 0, 12'h0A0, 0);
        chk_state("prio_call", 12'h0A0, 2'd1, 1'b0, 1'b0);
        cmd(3'd7, 0, 1, 0, 1, 12'h0C0, 0);
        chk_state("prio_jump", 12'h0C0, 2'd1, 1'b0, 1'b0);
        cmd(3'd7, 1, 0, 0, 1, 12'h000, 0);
        chk_state("prio_ret", 12'h051, 2'd0, 1'b0, 1'b0);

        cmd(3'd7, 0, 0, 1, 0, 12'h400, 0);
        cmd(3'd7, 0, 0, 1, 0, 12'h500, 0);
        chk_state("pre_rst", 12'h500, 2'd2, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_state("async_rst", 12'h000, 2'd0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        cmd(3'd7, 0, 0, 0, 1, 12'h000, 0);
        chk_state("post_rst_ret", 12'h001, 2'd0, 1'b0, FL);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
